// File: rtl/imm_target_pkg.sv
// Shared types for the pipelined immediate/target generator: opcodes,
// immediate format tags, the per-instruction result record and buffer states.
package imm_target_pkg;

  // Widest supported DataWidth; result records are sized for it and narrower
  // builds use the low bits.
  localparam int MaxDataWidth = 64;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef struct packed {
    logic [MaxDataWidth-1:0] imm;
    logic [MaxDataWidth-1:0] target;
    imm_type_e               imm_type;
    logic                    illegal;
  } imm_entry_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/imm_target_dec.sv
// Combinational decode of one RV32 instruction into its sign-extended immediate
// and control-flow target. Optional JALR target resolution: IMM_TARGET_JALR_EN.
module imm_target_dec
  import imm_target_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic [31:0]          instruction,
  input  logic [DataWidth-1:0] pc,
`ifdef IMM_TARGET_JALR_EN
  input  logic [DataWidth-1:0] rs1_data,
`endif
  output imm_entry_t           entry
);

  logic [6:0]           opcode;
  logic [DataWidth-1:0] imm_i;
  logic [DataWidth-1:0] imm_s;
  logic [DataWidth-1:0] imm_b;
  logic [DataWidth-1:0] imm_u;
  logic [DataWidth-1:0] imm_j;
  logic [DataWidth-1:0] imm;
  logic [DataWidth-1:0] pc_plus_4;
  logic [DataWidth-1:0] pc_rel;
  logic [DataWidth-1:0] target;
  imm_type_e            imm_type;
  logic                 illegal;
  logic                 use_pc_rel;
  logic                 is_jalr;

  assign opcode = instruction[6:0];

  // A sized cast of a signed operand sign-extends up to DataWidth.
  assign imm_i = DataWidth'($signed(instruction[31:20]));
  assign imm_s = DataWidth'($signed({instruction[31:25], instruction[11:7]}));
  assign imm_b = DataWidth'($signed({instruction[31], instruction[7],
                                     instruction[30:25], instruction[11:8], 1'b0}));
  assign imm_u = DataWidth'($signed({instruction[31:12], 12'b0}));
  assign imm_j = DataWidth'($signed({instruction[31], instruction[19:12],
                                     instruction[20], instruction[30:21], 1'b0}));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    imm_type   = IMM_NONE;
    illegal    = 1'b0;
    use_pc_rel = 1'b0;
    is_jalr    = 1'b0;
    unique case (opcode)
      OpLui:    imm_type = IMM_U;
      OpAuipc:  begin imm_type = IMM_U; use_pc_rel = 1'b1; end
      OpJal:    begin imm_type = IMM_J; use_pc_rel = 1'b1; end
      OpJalr:   begin imm_type = IMM_I; is_jalr    = 1'b1; end
      OpLoad,
      OpOpImm,
      OpSystem: imm_type = IMM_I;
      OpStore:  imm_type = IMM_S;
      OpBranch: begin imm_type = IMM_B; use_pc_rel = 1'b1; end
      default:  illegal  = 1'b1;
    endcase
  end

  always_comb begin
    imm = '0;
    unique case (imm_type)
      IMM_I:   imm = imm_i;
      IMM_S:   imm = imm_s;
      IMM_B:   imm = imm_b;
      IMM_U:   imm = imm_u;
      IMM_J:   imm = imm_j;
      default: imm = '0;
    endcase
  end

  assign pc_plus_4 = pc + DataWidth'(4);
  assign pc_rel    = pc + imm;

  always_comb begin
    target = pc_plus_4;
    if (use_pc_rel) begin
      target = pc_rel;
    end
`ifdef IMM_TARGET_JALR_EN
    if (is_jalr) begin
      target = (rs1_data + imm) & ~DataWidth'(1);
    end
`else
    // Without rs1 the jump cannot be resolved here; the consumer handles it.
    if (is_jalr) begin
      target = pc_plus_4;
    end
`endif
  end

  always_comb begin
    entry          = '0;
    entry.imm      = MaxDataWidth'(imm);
    entry.target   = MaxDataWidth'(target);
    entry.imm_type = imm_type;
    entry.illegal  = illegal;
  end

endmodule

// File: rtl/imm_target_gen.sv
// Registered immediate/target generator with a 2-entry skid buffer between
// fetch and decode. Optional rs1_data port for JALR targets: IMM_TARGET_JALR_EN.
module imm_target_gen
  import imm_target_pkg::*;
#(
  parameter int                   DataWidth = 32,
  parameter logic [DataWidth-1:0] ResetPc   = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instruction,
  input  logic [DataWidth-1:0] pc,
`ifdef IMM_TARGET_JALR_EN
  input  logic [DataWidth-1:0] rs1_data,
`endif
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DataWidth-1:0] out_imm,
  output logic [DataWidth-1:0] out_target,
  output imm_type_e            out_type,
  output logic                 out_illegal
);

  buf_state_e state_q;
  buf_state_e state_d;
  imm_entry_t dec_entry;
  imm_entry_t main_q;
  imm_entry_t skid_q;
  imm_entry_t out_entry;
  imm_entry_t reset_entry;
  logic       accept;
  logic       drain;
  logic       load_main;
  logic       load_skid;
  logic       skid_to_main;

  imm_target_dec #(
    .DataWidth (DataWidth)
  ) u_dec (
    .instruction (instruction),
    .pc          (pc),
`ifdef IMM_TARGET_JALR_EN
    .rs1_data    (rs1_data),
`endif
    .entry       (dec_entry)
  );

  // Both handshake outputs derive from the state register only, so out_ready
  // never reaches in_ready combinationally.
  assign in_ready  = rst_n && (state_q != BUF_TWO);
  assign out_valid = (state_q != BUF_EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      unique case (state_q)
        BUF_EMPTY: begin
          if (accept) begin
            state_d   = BUF_ONE;
            load_main = 1'b1;
          end
        end
        BUF_ONE: begin
          unique case ({accept, drain})
            2'b10: begin
              state_d   = BUF_TWO;
              load_skid = 1'b1;
            end
            2'b01:   state_d   = BUF_EMPTY;
            2'b11:   load_main = 1'b1;
            default: state_d   = BUF_ONE;
          endcase
        end
        BUF_TWO: begin
          // in_ready is low here, so only a drain can move the buffer.
          if (drain) begin
            state_d      = BUF_ONE;
            skid_to_main = 1'b1;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  // NOTE: the payload registers carry no reset; they are only loaded on an
  // accepted transfer and are never visible unless the state marks them valid.
  always_ff @(posedge clk) begin
    if (load_main) begin
      main_q <= dec_entry;
    end else if (skid_to_main) begin
      main_q <= skid_q;
    end
    if (load_skid) begin
      skid_q <= dec_entry;
    end
  end

  always_comb begin
    reset_entry          = '0;
    reset_entry.target   = MaxDataWidth'(ResetPc);
    reset_entry.imm_type = IMM_NONE;
    reset_entry.illegal  = 1'b0;
  end

  assign out_entry   = out_valid ? main_q : reset_entry;
  assign out_imm     = out_entry.imm[DataWidth-1:0];
  assign out_target  = out_entry.target[DataWidth-1:0];
  assign out_type    = out_entry.imm_type;
  assign out_illegal = out_entry.illegal;

  // Narrow builds leave the upper record bits idle; fold them into a sink.
  if (DataWidth < MaxDataWidth) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{out_entry.imm[MaxDataWidth-1:DataWidth],
                         out_entry.target[MaxDataWidth-1:DataWidth]};
  end

endmodule

// File: tb/tb_imm_target_gen.sv
// Directed, table-driven bench for imm_target_gen (32-bit and 64-bit instances),
// with hand-written sequences for backpressure, flush and mid-stream reset.
module tb_imm_target_gen;
  import imm_target_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [31:0] out_target;
  imm_type_e   out_type;
  logic        out_illegal;

  logic        in_valid64;
  logic        in_ready64;
  logic [31:0] instruction64;
  logic [63:0] pc64;
  logic [63:0] rs1_data64;
  logic        flush64;
  logic        out_valid64;
  logic        out_ready64;
  logic [63:0] out_imm64;
  logic [63:0] out_target64;
  imm_type_e   out_type64;
  logic        out_illegal64;

  int checks   = 0;
  int failures = 0;

`ifdef IMM_TARGET_JALR_EN
  localparam logic [31:0] JalrTarget = 32'h0000_0FFE;
`else
  localparam logic [31:0] JalrTarget = 32'h0000_0404;
`endif

  imm_target_gen #(
    .DataWidth (32),
    .ResetPc   (32'h0)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .pc          (pc),
`ifdef IMM_TARGET_JALR_EN
    .rs1_data    (rs1_data),
`endif
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_target  (out_target),
    .out_type    (out_type),
    .out_illegal (out_illegal)
  );

  imm_target_gen #(
    .DataWidth (64),
    .ResetPc   (64'h1000)
  ) u_dut64 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid64),
    .in_ready    (in_ready64),
    .instruction (instruction64),
    .pc          (pc64),
`ifdef IMM_TARGET_JALR_EN
    .rs1_data    (rs1_data64),
`endif
    .flush       (flush64),
    .out_valid   (out_valid64),
    .out_ready   (out_ready64),
    .out_imm     (out_imm64),
    .out_target  (out_target64),
    .out_type    (out_type64),
    .out_illegal (out_illegal64)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [31:0] target;
    imm_type_e   itype;
    logic        illegal;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name, input logic exp_in_ready);
    check({name, "_out_valid"}, 64'(out_valid), 64'd0);
    check({name, "_in_ready"}, 64'(in_ready), 64'(exp_in_ready));
    check({name, "_imm"}, 64'(out_imm), 64'd0);
    check({name, "_target"}, 64'(out_target), 64'd0);
    check({name, "_type"}, 64'(out_type), 64'(IMM_NONE));
    check({name, "_illegal"}, 64'(out_illegal), 64'd0);
  endtask

  task automatic present(input logic [31:0] i, input logic [31:0] p);
    in_valid    = 1'b1;
    instruction = i;
    pc          = p;
  endtask

  initial begin
    vecs[0]  = '{"beq",       32'hFE00_0CE3, 32'h100,  32'h0,    32'hFFFF_FFF8, 32'h0000_00F8, IMM_B,    1'b0};
    vecs[1]  = '{"lui",       32'h1234_50B7, 32'h200,  32'h0,    32'h1234_5000, 32'h0000_0204, IMM_U,    1'b0};
    vecs[2]  = '{"jal",       32'h0010_006F, 32'h1000, 32'h0,    32'h0000_0800, 32'h0000_1800, IMM_J,    1'b0};
    vecs[3]  = '{"sw",        32'hFE00_2E23, 32'h300,  32'h0,    32'hFFFF_FFFC, 32'h0000_0304, IMM_S,    1'b0};
    vecs[4]  = '{"auipc",     32'hFFFF_F097, 32'h2000, 32'h0,    32'hFFFF_F000, 32'h0000_1000, IMM_U,    1'b0};
    vecs[5]  = '{"addi",      32'h7FF0_0093, 32'h40,   32'h0,    32'h0000_07FF, 32'h0000_0044, IMM_I,    1'b0};
    vecs[6]  = '{"lw",        32'hFFF1_2083, 32'h50,   32'h0,    32'hFFFF_FFFF, 32'h0000_0054, IMM_I,    1'b0};
    vecs[7]  = '{"jalr",      32'hFFC0_8067, 32'h400,  32'h1003, 32'hFFFF_FFFC, JalrTarget,    IMM_I,    1'b0};
    vecs[8]  = '{"illegal",   32'h0000_007F, 32'h500,  32'h0,    32'h0000_0000, 32'h0000_0504, IMM_NONE, 1'b1};
    vecs[9]  = '{"ecall",     32'h0000_0073, 32'h600,  32'h0,    32'h0000_0000, 32'h0000_0604, IMM_I,    1'b0};
    vecs[10] = '{"beq_wrap",  32'hFE00_0CE3, 32'h0,    32'h0,    32'hFFFF_FFF8, 32'hFFFF_FFF8, IMM_B,    1'b0};

    rst_n         = 1'b0;
    in_valid      = 1'b0;
    instruction   = '0;
    pc            = '0;
    rs1_data      = '0;
    flush         = 1'b0;
    out_ready     = 1'b0;
    in_valid64    = 1'b0;
    instruction64 = '0;
    pc64          = '0;
    rs1_data64    = '0;
    flush64       = 1'b0;
    out_ready64   = 1'b1;

    // Reset state, including in_ready low while held in reset.
    tick();
    tick();
    check_idle("reset", 1'b0);
    check("reset64_target", out_target64, 64'h1000);
    check("reset64_valid", 64'(out_valid64), 64'd0);
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Table: streaming with out_ready=1, one result per cycle.
    out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      present(vecs[k].instr, vecs[k].pc);
      rs1_data = vecs[k].rs1;
      tick();
      check({vecs[k].name, "_valid"}, 64'(out_valid), 64'd1);
      check({vecs[k].name, "_imm"}, 64'(out_imm), 64'(vecs[k].imm));
      check({vecs[k].name, "_target"}, 64'(out_target), 64'(vecs[k].target));
      check({vecs[k].name, "_type"}, 64'(out_type), 64'(vecs[k].itype));
      check({vecs[k].name, "_illegal"}, 64'(out_illegal), 64'(vecs[k].illegal));
    end

    // X on the inputs while in_valid=0 must not disturb the held result.
    out_ready   = 1'b0;
    in_valid    = 1'b0;
    instruction = 'x;
    pc          = 'x;
    tick();
    check("xin_imm", 64'(out_imm), 64'hFFFF_FFF8);
    check("xin_target", 64'(out_target), 64'hFFFF_FFF8);
    out_ready = 1'b1;
    tick();
    check_idle("drained", 1'b1);

    // Backpressure: A accepted, B into skid, C held off for 5 cycles.
    out_ready = 1'b0;
    present(32'h1234_50B7, 32'h10);
    tick();
    check("bp_a_in_ready", 64'(in_ready), 64'd1);
    check("bp_a_imm", 64'(out_imm), 64'h1234_5000);
    present(32'h0010_006F, 32'h20);
    tick();
    check("bp_b_in_ready", 64'(in_ready), 64'd0);
    present(32'hFE00_2E23, 32'h30);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold_imm", 64'(out_imm), 64'h1234_5000);
      check("bp_hold_target", 64'(out_target), 64'h14);
      check("bp_hold_type", 64'(out_type), 64'(IMM_U));
    end
    out_ready = 1'b1;
    tick();
    check("bp_b_valid", 64'(out_valid), 64'd1);
    check("bp_b_imm", 64'(out_imm), 64'h800);
    check("bp_b_target", 64'(out_target), 64'h820);
    check("bp_b_reopen", 64'(in_ready), 64'd1);
    tick();
    check("bp_c_imm", 64'(out_imm), 64'hFFFF_FFFC);
    check("bp_c_target", 64'(out_target), 64'h34);
    check("bp_c_type", 64'(out_type), 64'(IMM_S));
    in_valid = 1'b0;
    tick();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Flush in TWO with a simultaneous in_valid.
    out_ready = 1'b0;
    present(32'h1234_50B7, 32'h10);
    tick();
    present(32'h0010_006F, 32'h20);
    tick();
    check("fl_two_in_ready", 64'(in_ready), 64'd0);
    present(32'hFE00_2E23, 32'h30);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_idle("fl_two", 1'b1);
    out_ready = 1'b1;
    tick();
    check("fl_two_gone", 64'(out_valid), 64'd0);

    // Flush in ONE: in_ready is high but the same-cycle instruction is dropped.
    out_ready = 1'b0;
    present(32'h1234_50B7, 32'h10);
    tick();
    present(32'h7FF0_0093, 32'h40);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_idle("fl_one", 1'b1);
    tick();
    check("fl_one_gone", 64'(out_valid), 64'd0);

    // Reset for one cycle while in TWO.
    present(32'h1234_50B7, 32'h10);
    tick();
    present(32'h0010_006F, 32'h20);
    tick();
    rst_n = 1'b0;
    present(32'hFE00_2E23, 32'h30);
    #1;
    check("rst_mid_in_ready", 64'(in_ready), 64'd0);
    tick();
    check_idle("rst_mid", 1'b0);
    rst_n = 1'b1;
    #1;
    check("rst_mid_release_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_release_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    tick();
    check("rst_mid_resume_imm", 64'(out_imm), 64'hFFFF_FFFC);
    check("rst_mid_resume_target", 64'(out_target), 64'h34);
    in_valid = 1'b0;
    tick();

    // 64-bit instance: sign extension to 64 bits and wrap-around target.
    in_valid64    = 1'b1;
    instruction64 = 32'hFE00_0CE3;
    pc64          = 64'h0;
    tick();
    check("w64_beq_imm", out_imm64, 64'hFFFF_FFFF_FFFF_FFF8);
    check("w64_beq_target", out_target64, 64'hFFFF_FFFF_FFFF_FFF8);
    check("w64_beq_type", 64'(out_type64), 64'(IMM_B));
    instruction64 = 32'h0000_007F;
    pc64          = 64'h8;
    tick();
    check("w64_ill_illegal", 64'(out_illegal64), 64'd1);
    check("w64_ill_imm", out_imm64, 64'h0);
    check("w64_ill_target", out_target64, 64'hC);
    instruction64 = 32'hFFFF_F097;
    pc64          = 64'h2000;
    tick();
    check("w64_auipc_imm", out_imm64, 64'hFFFF_FFFF_FFFF_F000);
    check("w64_auipc_target", out_target64, 64'h1000);
    in_valid64 = 1'b0;
    tick();
    check("w64_empty_target", out_target64, 64'h1000);
    check("w64_empty_valid", 64'(out_valid64), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
